// File: rtl/slime_pkg.sv
// Shared constants and types for the slime contact detector: coordinate width,
// hitbox sizes, confirm/cooldown frame counts and the evaluation FSM states.
package slime_pkg;

    localparam int COORD_W         = 10;
    localparam int PLAYER_W        = 32;
    localparam int PLAYER_H        = 32;
    localparam int SLIME_W         = 32;
    localparam int SLIME_H         = 24;
    localparam int CONFIRM_FRAMES  = 2;
    localparam int COOLDOWN_FRAMES = 15;
    localparam int STOMP_MARGIN    = 6;

    localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);
    localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so edge sums never wrap.
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK0 = 2'd1,
        CHECK1 = 2'd2,
        ISSUE  = 2'd3
    } state_e;

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap test between box A and box B (top-left corners).
// Touching edges do not count; sums are done one bit wider than the coordinates.
module aabb_overlap #(
    parameter int COORD_W = 10,
    parameter int A_W     = 32,
    parameter int A_H     = 32,
    parameter int B_W     = 32,
    parameter int B_H     = 24
) (
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    output logic               overlap_o
);

    logic [COORD_W:0] ax, ay, bx, by;

    assign ax = {1'b0, ax_i};
    assign ay = {1'b0, ay_i};
    assign bx = {1'b0, bx_i};
    assign by = {1'b0, by_i};

    assign overlap_o = (ax < bx + (COORD_W+1)'(B_W)) &&
                       (bx < ax + (COORD_W+1)'(A_W)) &&
                       (ay < by + (COORD_W+1)'(B_H)) &&
                       (by < ay + (COORD_W+1)'(A_H));

endmodule

// File: rtl/slime_contact_detect.sv
// Per-frame player/slime contact detector issuing debounced, cooled-down damage pulses.
// Optional stomp kills are enabled with the SLIME_STOMP_EN macro.
module slime_contact_detect
    import slime_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick_i,
    input  logic [COORD_W-1:0] player_x_i,
    input  logic [COORD_W-1:0] player_y_i,
    input  logic [COORD_W-1:0] slime0_x_i,
    input  logic [COORD_W-1:0] slime0_y_i,
    input  logic [COORD_W-1:0] slime1_x_i,
    input  logic [COORD_W-1:0] slime1_y_i,
    input  logic [1:0]   slime_alive_i,
    input  logic [3:0]   health_i,
    input  logic         player_falling_i,
    output logic [1:0]   slim_damage_o,
    output logic [1:0]   slime_kill_o,
    output logic         tick_overrun_o
);

    state_e state_q, state_d;

    coord_t       px_q, py_q;
    coord_t [1:0] sx_q, sy_q;
    logic [1:0]   alive_q;
    logic [3:0]   health_q;

    logic [1:0][CONF_W-1:0] conf_q;
    logic [1:0][CD_W-1:0]   cd_q;
    logic [1:0] hit_q, kill_q, dmg_q, kill_out_q;
    logic       ovr_q;

    logic              sel, overlap, live_ov, stomp, hit_d, kill_d;
    logic [CONF_W-1:0] conf_d;
    logic [CD_W-1:0]   cd_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = frame_tick_i ? CHECK0 : IDLE;
            CHECK0:  state_d = CHECK1;
            CHECK1:  state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Single comparator shared by both check states.
    assign sel = (state_q == CHECK1);

    aabb_overlap #(
        .COORD_W (COORD_W),
        .A_W     (PLAYER_W),
        .A_H     (PLAYER_H),
        .B_W     (SLIME_W),
        .B_H     (SLIME_H)
    ) u_aabb (
        .ax_i      (px_q),
        .ay_i      (py_q),
        .bx_i      (sx_q[sel]),
        .by_i      (sy_q[sel]),
        .overlap_o (overlap)
    );

    assign live_ov = alive_q[sel] & overlap;

`ifdef SLIME_STOMP_EN
    logic falling_q;
    assign stomp = live_ov && falling_q &&
                   (coord_ext_t'(py_q) + coord_ext_t'(PLAYER_H) <=
                    coord_ext_t'(sy_q[sel]) + coord_ext_t'(STOMP_MARGIN));
`else
    logic unused_falling;
    assign unused_falling = player_falling_i;
    assign stomp = 1'b0;
`endif

    always_comb begin
        conf_d = '0;
        if (live_ov && !stomp)
            conf_d = (conf_q[sel] == CONF_W'(CONFIRM_FRAMES)) ? conf_q[sel]
                                                              : conf_q[sel] + CONF_W'(1);
        cd_d   = cd_q[sel];
        hit_d  = 1'b0;
        kill_d = stomp;
        // A stomp still lets the cooldown run down but never arms a hit.
        if (cd_q[sel] != '0) begin
            cd_d = cd_q[sel] - CD_W'(1);
        end else if (!stomp && conf_d == CONF_W'(CONFIRM_FRAMES) && health_q != '0) begin
            hit_d = 1'b1;
            cd_d  = CD_W'(COOLDOWN_FRAMES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            alive_q    <= '0;
            health_q   <= '0;
            conf_q     <= '0;
            cd_q       <= '0;
            hit_q      <= '0;
            kill_q     <= '0;
            dmg_q      <= '0;
            kill_out_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dmg_q      <= '0;
            kill_out_q <= '0;
            if (frame_tick_i && state_q != IDLE)
                ovr_q <= 1'b1;
            case (state_q)
                IDLE: if (frame_tick_i) begin
                    px_q     <= player_x_i;
                    py_q     <= player_y_i;
                    sx_q[0]  <= slime0_x_i;
                    sy_q[0]  <= slime0_y_i;
                    sx_q[1]  <= slime1_x_i;
                    sy_q[1]  <= slime1_y_i;
                    alive_q  <= slime_alive_i;
                    health_q <= health_i;
                    hit_q    <= '0;
                    kill_q   <= '0;
                end
                CHECK0, CHECK1: begin
                    conf_q[sel] <= conf_d;
                    cd_q[sel]   <= cd_d;
                    hit_q[sel]  <= hit_d;
                    kill_q[sel] <= kill_d;
                end
                default: begin
                    dmg_q      <= hit_q;
                    kill_out_q <= kill_q;
                end
            endcase
        end
    end

`ifdef SLIME_STOMP_EN
    always_ff @(posedge clk) begin
        if (reset)
            falling_q <= 1'b0;
        else if (state_q == IDLE && frame_tick_i)
            falling_q <= player_falling_i;
    end
`endif

    assign slim_damage_o  = dmg_q;
    assign slime_kill_o   = kill_out_q;
    assign tick_overrun_o = ovr_q;

endmodule

// File: tb/tb_slime_contact_detect.sv
// Randomized and directed bench for slime_contact_detect against a per-frame behavioural model.
module tb_slime_contact_detect;

    localparam int PW = 32, PH = 32, SW = 32, SH = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] d_px, d_py, d_s0x, d_s0y, d_s1x, d_s1y;
    logic [1:0] d_alive;
    logic [3:0] d_hp;
    logic       d_fall;
    logic [1:0] slim_damage, slime_kill;
    logic       tick_overrun;

    // frame stimulus (what the DUT should latch on the tick)
    int px, py, s0x, s0y, s1x, s1y;
    logic [1:0] alive;
    logic [3:0] hp;
    logic       fall;

    int m_conf[2], m_cd[2];
    logic exp_ovr;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    slime_contact_detect dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick_i     (frame_tick),
        .player_x_i       (d_px),
        .player_y_i       (d_py),
        .slime0_x_i       (d_s0x),
        .slime0_y_i       (d_s0y),
        .slime1_x_i       (d_s1x),
        .slime1_y_i       (d_s1y),
        .slime_alive_i    (d_alive),
        .health_i         (d_hp),
        .player_falling_i (d_fall),
        .slim_damage_o    (slim_damage),
        .slime_kill_o     (slime_kill),
        .tick_overrun_o   (tick_overrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame of the game rules, applied to the model's per-slime counters.
    task automatic model_frame(output logic [1:0] dmg, output logic [1:0] kill);
        dmg  = 2'b00;
        kill = 2'b00;
        for (int i = 0; i < 2; i++) begin
            int  sx = (i == 0) ? s0x : s1x;
            int  sy = (i == 0) ? s0y : s1y;
            bit  ov;
            bit  st;
            ov = alive[i] && (px < sx + SW) && (sx < px + PW) && (py < sy + SH) && (sy < py + PH);
            st = 1'b0;
`ifdef SLIME_STOMP_EN
            st = ov && fall && (py + PH <= sy + 6);
`endif
            if (st) begin
                kill[i]   = 1'b1;
                m_conf[i] = 0;
                if (m_cd[i] > 0) m_cd[i]--;
            end else begin
                m_conf[i] = ov ? ((m_conf[i] < 2) ? m_conf[i] + 1 : 2) : 0;
                if (m_cd[i] > 0) m_cd[i]--;
                else if (m_conf[i] == 2 && hp != 0) begin
                    dmg[i]  = 1'b1;
                    m_cd[i] = 15;
                end
            end
        end
    endtask

    task automatic apply_stim();
        d_px = 10'(px); d_py = 10'(py);
        d_s0x = 10'(s0x); d_s0y = 10'(s0y);
        d_s1x = 10'(s1x); d_s1y = 10'(s1y);
        d_alive = alive; d_hp = hp; d_fall = fall;
    endtask

    task automatic scramble();
        d_px = 10'($urandom); d_py = 10'($urandom);
        d_s0x = 10'($urandom); d_s0y = 10'($urandom);
        d_s1x = 10'($urandom); d_s1y = 10'($urandom);
        d_alive = 2'($urandom); d_hp = 4'($urandom); d_fall = 1'($urandom);
    endtask

    task automatic sample(input string tag, input logic [1:0] ed, input logic [1:0] ek);
        chk({tag, "_dmg"},  int'(slim_damage), int'(ed));
        chk({tag, "_kill"}, int'(slime_kill),  int'(ek));
        chk({tag, "_ovr"},  int'(tick_overrun), int'(exp_ovr));
    endtask

    // Tick, then check every cycle up to one past the expected pulse edge.
    task automatic do_frame(input bit extra_tick, output logic [1:0] obs_dmg, output logic [1:0] obs_kill);
        logic [1:0] ed, ek;
        model_frame(ed, ek);
        apply_stim();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        scramble();
        sample("e1", 2'b00, 2'b00);
        if (extra_tick) begin
            frame_tick = 1'b1;
            exp_ovr = 1'b1;
        end
        @(posedge clk); #1;
        frame_tick = 1'b0;
        sample("e2", 2'b00, 2'b00);
        @(posedge clk); #1;
        sample("e3", 2'b00, 2'b00);
        @(posedge clk); #1;
        sample("e4", ed, ek);
        obs_dmg  = slim_damage;
        obs_kill = slime_kill;
        @(posedge clk); #1;
        sample("e5", 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_conf = '{0, 0};
        m_cd   = '{0, 0};
        exp_ovr = 1'b0;
        sample("rst", 2'b00, 2'b00);
    endtask

    task automatic set_pos(input int a, input int b, input int c, input int d, input int e, input int f);
        px = a; py = b; s0x = c; s0y = d; s1x = e; s1y = f;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] od, ok;
        set_pos(100, 100, 120, 110, 600, 600);
        alive = 2'b01; hp = 4'd3; fall = 1'b0;
        exp_ovr = 1'b0;
        apply_stim();
        @(posedge clk); #1;
        do_reset();

        // basic two-frame confirm
        do_frame(0, od, ok); chk("t1_f1", int'(od), 0);
        do_frame(0, od, ok); chk("t1_f2", int'(od), 1);

        // touching edge is not an overlap
        do_reset();
        set_pos(100, 100, 132, 100, 600, 600);
        for (int f = 0; f < 5; f++) begin
            do_frame(0, od, ok); chk("t2_edge", int'(od), 0);
        end

        // held overlap: confirm then cooldown
        do_reset();
        set_pos(100, 100, 120, 110, 600, 600);
        for (int f = 1; f <= 20; f++) begin
            do_frame(0, od, ok); chk("t3_hold", int'(od), (f == 2 || f == 18) ? 1 : 0);
        end

        // both slimes in one pulse
        do_reset();
        set_pos(100, 100, 120, 110, 90, 95);
        alive = 2'b11;
        do_frame(0, od, ok); chk("t4_f1", int'(od), 0);
        do_frame(0, od, ok); chk("t4_f2", int'(od), 3);

        // dead player takes no damage, counters keep running
        do_reset();
        set_pos(100, 100, 120, 110, 600, 600);
        alive = 2'b01; hp = 4'd0;
        for (int f = 0; f < 4; f++) begin
            do_frame(0, od, ok); chk("t5_dead", int'(od), 0);
        end
        hp = 4'd3;
        do_frame(0, od, ok); chk("t5_alive", int'(od), 1);

        // reset in the middle of a frame evaluation
        do_reset();
        do_frame(0, od, ok); chk("t6_f1", int'(od), 0);
        apply_stim();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_conf = '{0, 0};
        m_cd   = '{0, 0};
        for (int c = 0; c < 4; c++) begin
            sample("t6_abort", 2'b00, 2'b00);
            @(posedge clk); #1;
        end
        do_frame(0, od, ok); chk("t6_f2", int'(od), 0);
        do_frame(0, od, ok); chk("t6_f3", int'(od), 1);

        // tick while busy sets a sticky overrun flag
        do_reset();
        do_frame(1, od, ok);
        chk("t7_ovr", int'(tick_overrun), 1);
        do_frame(0, od, ok);
        chk("t7_hold", int'(tick_overrun), 1);
        do_reset();

`ifdef SLIME_STOMP_EN
        set_pos(100, 80, 100, 110, 600, 600);
        alive = 2'b01; hp = 4'd3; fall = 1'b1;
        do_frame(0, od, ok);
        chk("t8_kill", int'(ok), 1);
        chk("t8_dmg", int'(od), 0);
        fall = 1'b0;
        do_reset();
`endif

        // randomized play around the player
        for (int f = 0; f < 150; f++) begin
            if (f == 0 || $urandom_range(3) == 0) begin
                px  = $urandom_range(900, 60);
                py  = $urandom_range(900, 60);
                s0x = px + $urandom_range(80) - 40;
                s0y = py + $urandom_range(80) - 40;
                s1x = px + $urandom_range(80) - 40;
                s1y = py + $urandom_range(80) - 40;
            end
            alive = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b11;
            hp    = ($urandom_range(5) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            fall  = 1'($urandom);
            do_frame(($urandom_range(15) == 0), od, ok);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
